// File: rtl/timer_display_pkg.sv
// Shared types and constants for the timer display slice.
package timer_display_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segment patterns, bit0=a .. bit6=g.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // 10**n, used to check that the BCD field can hold the widest count.
  function automatic longint unsigned pow10(int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/timer_display_if.sv
// Count/display link between the countdown timer and its display block.
interface timer_display_if #(
  parameter int unsigned WIDTH  = 19,
  parameter int unsigned DIGITS = 6
);
  logic [WIDTH-1:0]    value;
  logic                display_on;
  logic [7*DIGITS-1:0] hex_n;
  logic [DIGITS-1:0]   dp_n;
  logic                busy;
  logic                upd;

  modport master (output value, display_on, input hex_n, dp_n, busy, upd);
  modport slave  (input value, display_on, output hex_n, dp_n, busy, upd);
endinterface

// File: rtl/seg7_decode.sv
// BCD nibble to active-low seven-segment pattern; out-of-range nibbles blank.
module seg7_decode
  import timer_display_pkg::*;
(
  input  bcd_digit_t  digit_i,
  input  logic        blank_i,
  output logic [6:0]  seg_o
);

  // Table lookup with forced blank.
  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (digit_i)
        4'd0:    seg_o = SEG_DIGIT[0];
        4'd1:    seg_o = SEG_DIGIT[1];
        4'd2:    seg_o = SEG_DIGIT[2];
        4'd3:    seg_o = SEG_DIGIT[3];
        4'd4:    seg_o = SEG_DIGIT[4];
        4'd5:    seg_o = SEG_DIGIT[5];
        4'd6:    seg_o = SEG_DIGIT[6];
        4'd7:    seg_o = SEG_DIGIT[7];
        4'd8:    seg_o = SEG_DIGIT[8];
        4'd9:    seg_o = SEG_DIGIT[9];
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/timer_display.sv
// Binary count -> BCD (sequential double-dabble) -> registered seven-segment drive.
module timer_display
  import timer_display_pkg::*;
#(
  parameter int unsigned WIDTH    = 19,
  parameter int unsigned DIGITS   = 6,
  parameter int unsigned DP_DIGIT = 2,
  parameter int unsigned LZB      = 1
) (
  input  logic           clk,
  input  logic           reset,
  timer_display_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned BW = 4 * DIGITS;

  if (((64'd1 << WIDTH) - 64'd1) > (pow10(DIGITS) - 64'd1)) begin : g_width_chk
    $error("timer_display: WIDTH too large for DIGITS");
  end

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [BW-1:0]     acc_q, acc_d, adj;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [WIDTH-1:0]  last_q, last_d;
  logic              lv_q, lv_d;
  logic              start;
  logic              upd_q, upd_d;
  logic              busy_o;
  logic [DIGITS-1:0] blank;
  logic              zero_run;
  logic [7*DIGITS-1:0] seg_w, hex_q, hex_d;
  logic [DIGITS-1:0] dp_q, dp_d;

  assign start = !lv_q || (bus.value != last_q);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy for the whole conversion, upd registered on the DONE edge.
  always_comb begin
    busy_o = (state_q != IDLE);
    upd_d  = (state_q == DONE);
  end

  // Double-dabble datapath next-state.
  // last_q is loaded at capture rather than at DONE: it is only compared in
  // IDLE and lv_q is only set at DONE, so the observable behaviour is the same.
  always_comb begin
    bin_d  = bin_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    bcd_d  = bcd_q;
    last_d = last_q;
    lv_d   = lv_q;
    adj    = acc_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d  = bus.value;
          last_d = bus.value;
          acc_d  = '0;
          cnt_d  = '0;
        end
      end
      SHIFT: begin
        {acc_d, bin_d} = {adj[BW-2:0], bin_q, 1'b0};
        cnt_d          = cnt_q + CW'(1);
      end
      DONE: begin
        bcd_d = acc_q;
        lv_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_q  <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      bcd_q  <= '0;
      last_q <= '0;
      lv_q   <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      bcd_q  <= bcd_d;
      last_q <= last_d;
      lv_q   <= lv_d;
    end
  end

  // Leading-zero blanking, scanning from the most significant digit down.
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      zero_run = zero_run && (bcd_q[4*(DIGITS-1-k) +: 4] == 4'd0);
      if ((LZB != 0) && ((DIGITS - 1 - k) > DP_DIGIT) && zero_run)
        blank[DIGITS-1-k] = 1'b1;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_decode u_dec (
      .digit_i (bcd_q[4*g +: 4]),
      .blank_i (blank[g]),
      .seg_o   (seg_w[7*g +: 7])
    );
  end

  // Output register next-state: flash gating and fixed decimal point.
  always_comb begin
    hex_d = '1;
    dp_d  = '1;
    if (bus.display_on) begin
      hex_d = seg_w;
      dp_d  = ~(DIGITS'(1) << DP_DIGIT);
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hex_q <= '1;
      dp_q  <= '1;
      upd_q <= 1'b0;
    end else begin
      hex_q <= hex_d;
      dp_q  <= dp_d;
      upd_q <= upd_d;
    end
  end

  assign bus.hex_n = hex_q;
  assign bus.dp_n  = dp_q;
  assign bus.busy  = busy_o;
  assign bus.upd   = upd_q;

endmodule

// File: tb/tb_timer_display.sv
// Randomised and directed checks of timer_display against a decimal reference model.
module tb_timer_display;

  localparam int unsigned W  = 19;
  localparam int unsigned ND = 6;
  localparam int unsigned DP = 2;
  localparam logic [41:0] ALL1 = '1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  timer_display_if #(.WIDTH(W), .DIGITS(ND)) ifa ();
  timer_display_if #(.WIDTH(W), .DIGITS(ND)) ifb ();

  assign ifb.value      = ifa.value;
  assign ifb.display_on = ifa.display_on;

  timer_display #(.WIDTH(W), .DIGITS(ND), .DP_DIGIT(DP), .LZB(1)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  timer_display #(.WIDTH(W), .DIGITS(ND), .DP_DIGIT(DP), .LZB(0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int upd_cyc[$];

  logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Reference model state.
  int unsigned  m_phase;
  logic [W-1:0] m_snap, m_last;
  bit           m_valid, m_upd;
  int unsigned  m_shown;
  logic [41:0]  m_hex_a, m_hex_b;
  logic [5:0]   m_dp;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [41:0] exp_hex(int unsigned v, bit lzb);
    logic [41:0] r;
    int unsigned p;
    int unsigned dig;
    p = 1;
    r = '0;
    for (int d = 0; d < ND; d++) begin
      dig = (v / p) % 10;
      if (lzb && d > DP && v < p) r[7*d +: 7] = 7'h7F;
      else                        r[7*d +: 7] = segtab[dig];
      p = p * 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_valid = 0;
    m_shown = 0;
    m_upd   = 0;
    m_snap  = '0;
    m_last  = '0;
    m_hex_a = '1;
    m_hex_b = '1;
    m_dp    = '1;
  endtask

  // One clock edge of the behavioural model: display shows what was converted
  // before this edge; a conversion takes WIDTH+1 edges after the capture edge.
  task automatic model_edge();
    if (!reset) begin
      model_reset();
    end else begin
      m_hex_a = ifa.display_on ? exp_hex(m_shown, 1'b1) : '1;
      m_hex_b = ifa.display_on ? exp_hex(m_shown, 1'b0) : '1;
      m_dp    = ifa.display_on ? ~(6'd1 << DP) : '1;
      m_upd   = 0;
      if (m_phase == 0) begin
        if (!m_valid || ifa.value != m_last) begin
          m_snap  = ifa.value;
          m_phase = 1;
        end
      end else if (m_phase == W + 1) begin
        m_shown = int'(m_snap);
        m_last  = m_snap;
        m_valid = 1;
        m_upd   = 1;
        m_phase = 0;
      end else begin
        m_phase++;
      end
    end
  endtask

  task automatic compare_all();
    chk("busy_a", ifa.busy, (m_phase != 0));
    chk("busy_b", ifb.busy, (m_phase != 0));
    chk("upd_a", ifa.upd, m_upd);
    chk("hex_a", ifa.hex_n, m_hex_a);
    chk("dp_a", ifa.dp_n, m_dp);
    chk("hex_b", ifb.hex_n, m_hex_b);
    chk("dp_b", ifb.dp_n, m_dp);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    if (ifa.upd) upd_cyc.push_back(cyc);
    compare_all();
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    #1;
    model_reset();
    compare_all();
  endtask

  initial begin
    int i;
    int gap;
    reset          = 1'b0;
    ifa.value      = '0;
    ifa.display_on = 1'b1;
    model_reset();
    steps(3);

    // 1: value 0 after reset, upd latency
    reset = 1'b1;
    for (i = 0; i <= 40; i++) begin
      step();
      if (ifa.upd) break;
    end
    chk("upd_latency", i, 20);
    step();
    chk("zero_hex", ifa.hex_n, {7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40});
    chk("zero_dp", ifa.dp_n, 6'b111011);

    // 2: 1000, with and without blanking
    ifa.value = 19'd1000;
    steps(25);
    chk("k1000_lzb", ifa.hex_n, {7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40, 7'h40});
    chk("k1000_nolzb", ifb.hex_n, {7'h40, 7'h40, 7'h79, 7'h40, 7'h40, 7'h40});

    // 3: full-scale
    ifa.value = 19'd524287;
    steps(25);
    chk("max_hex", ifa.hex_n, {7'h12, 7'h24, 7'h19, 7'h24, 7'h00, 7'h78});

    // 4: change mid-conversion
    upd_cyc.delete();
    ifa.value = 19'd500;
    steps(5);
    ifa.value = 19'd499;
    steps(50);
    gap = (upd_cyc.size() == 2) ? (upd_cyc[1] - upd_cyc[0]) : -1;
    chk("upd_gap", gap, 21);
    chk("k499_hex", ifa.hex_n, exp_hex(499, 1'b1));

    // 5: flash control
    ifa.value = 19'd1234;
    steps(25);
    ifa.display_on = 1'b0;
    step();
    chk("flash_off_hex", ifa.hex_n, ALL1);
    chk("flash_off_dp", ifa.dp_n, 6'h3F);
    ifa.display_on = 1'b1;
    step();
    chk("flash_on_hex", ifa.hex_n, {7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19});

    // 6: reset mid-conversion
    ifa.value = 19'd777;
    steps(10);
    chk("busy_before_rst", ifa.busy, 1'b1);
    assert_reset();
    steps(2);
    reset = 1'b1;
    steps(25);
    chk("k777_hex", ifa.hex_n, {7'h7F, 7'h7F, 7'h7F, 7'h78, 7'h78, 7'h78});

    // Randomised traffic
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0:       ifa.value = W'($urandom_range(0, 99));
        1:       ifa.value = W'($urandom_range(0, 9999));
        default: ifa.value = W'($urandom % 524288);
      endcase
      for (int k = 0, hold = $urandom_range(1, 40); k < hold; k++) begin
        if ($urandom_range(0, 9) == 0) ifa.display_on = ~ifa.display_on;
        step();
      end
      if ($urandom_range(0, 19) == 0) begin
        assert_reset();
        steps($urandom_range(1, 3));
        reset = 1'b1;
      end
      ifa.display_on = 1'b1;
    end
    steps(25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_display.md
Name: timer_display

Overview:
Consumer end of the countdown timer's count/display interface. Takes the timer's binary count (hundredths of a second) and its display_on flash control. Converts the count to BCD with a sequential shift-add-3 (double-dabble) engine and drives active-low seven-segment digits with a fixed decimal point and leading-zero blanking. Sits between the timer and the board HEX pins.

Parameters:
WIDTH, 19, bit width of the input count; must satisfy 2^WIDTH-1 <= 10^DIGITS-1 (elaboration-time check)
DIGITS, 6, number of seven-segment digits driven
DP_DIGIT, 2, index of the digit whose decimal point is lit (seconds.hundredths)
LZB, 1, 1 = blank leading zeros above DP_DIGIT; 0 = show all digits

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
value  in  WIDTH  binary count from timer
display_on  in  1  1 = show digits; 0 = all segments and points off (flash)
hex_n  out  7*DIGITS  segments; digit d at [7d+6:7d]; bit0=a..bit6=g; active-low
dp_n  out  DIGITS  decimal points, active-low
busy  out  1  high while a conversion is in progress (SHIFT or DONE)
upd  out  1  one-cycle pulse on the edge where displayed BCD changes

Behaviour:
- Reset (reset=0, async): state=IDLE; bcd_q=0; last_valid=0; hex_n all 1; dp_n all 1; busy=0; upd=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: if last_valid=0 or value!=last_value, capture value into shift reg, clear BCD accum, cnt=0 -> SHIFT. Else stay.
- SHIFT: each cycle, add 3 to every BCD nibble >=5, then shift {bcd,bin} left by 1; cnt++. After WIDTH shifts -> DONE.
- DONE: bcd_q <= accum; last_value <= captured value; last_valid=1; upd=1 for this edge only; -> IDLE.
- Latency: value sampled at edge E0. Shifts occur at E1..E_WIDTH. bcd_q and upd update at E_WIDTH+1 (E20 for default). hex_n/dp_n update at E_WIDTH+2 (21 cycles).
- Value changes mid-conversion are ignored; the captured snapshot finishes. Next IDLE compares against last_value and reconverts (one idle cycle between conversions).
- Constant value: no reconversion after first; busy stays 0.
- Output register, updated every cycle:
  - display_on=0: hex_n all 1, dp_n all 1.
  - Otherwise each digit shows SEG_DIGIT[bcd_q digit].
  - dp_n[DP_DIGIT]=0, other dp_n bits 1.
  - LZB=1: digit d>DP_DIGIT is blank (7'h7F) when it and all higher digits are 0; digits <=DP_DIGIT are never blanked.
- display_on affects outputs one edge after change; it never stalls conversion.
- Encoding (active-low, g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111.
- Reset mid-conversion: abort immediately to reset values. After release, reconvert the current value (last_valid=0).
- Nibble values >9 cannot occur; the decoder maps them to blank.

Decomposition:
- Package timer_display_pkg:
  - state enum {IDLE, SHIFT, DONE}
  - SEG_DIGIT[0:9] constants
  - SEG_BLANK=7'h7F
  - bcd_digit_t (4-bit) typedef
- Sub-module seg7_decode: combinational BCD nibble + blank -> 7-bit active-low segments. Instantiated DIGITS times.
- Double-dabble engine and FSM stay in timer_display.

Test Plan:
1. Reset release, value=0, display_on=1 -> upd pulse at edge 20. At edge 21: hex0..hex2=1000000, dp_n=111011, hex3..hex5=1111111.
2. value=1000 -> after 21 cycles: hex3=1111001, hex2..hex0=1000000, hex4/hex5 blank. With LZB=0: hex4/hex5=1000000.
3. value=524287 -> digits 5,2,4,2,8,7: hex5=0010010, hex4=0100100, hex3=0011001, hex2=0100100, hex1=0000000, hex0=1111000.
4. value 500 held, changed to 499 five cycles into conversion -> display shows 500, then 499. Two upd pulses 21 cycles apart. busy low only for the one IDLE cycle between them.
5. Toggle display_on 1->0->1 at steady value 1234 -> one edge later all hex_n/dp_n=1. Restore shows 12.34 digits. busy/upd unaffected.
6. Assert reset at cycle 10 of a conversion of 777 -> outputs blank and busy=0 asynchronously. After release, 777 displayed 21 cycles later.
